// File: rtl/jedro_1_mem_arbiter.sv
// Arbiter that lets the jedro_1 IFU and LSU share one single-port RAM.
// LSU wins conflicts unless IFU was denied MAX_STALL times in a row. Define
// JEDRO_1_MEM_ARB_STATS_EN to add the grant and conflict statistics counters.
module jedro_1_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_STALL  = 4
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    ifu_req_i,
    input  logic [ADDR_WIDTH-1:0]   ifu_addr_i,
    output logic                    ifu_gnt_o,
    output logic                    ifu_rvalid_o,
    output logic [DATA_WIDTH-1:0]   ifu_rdata_o,
    input  logic                    lsu_req_i,
    input  logic                    lsu_we_i,
    input  logic [DATA_WIDTH/8-1:0] lsu_be_i,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr_i,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
    output logic                    lsu_gnt_o,
    output logic                    lsu_rvalid_o,
    output logic [DATA_WIDTH-1:0]   lsu_rdata_o,
    output logic                    ram_en_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
`ifdef JEDRO_1_MEM_ARB_STATS_EN
    ,
    output logic [31:0]             stat_ifu_gnt_o,
    output logic [31:0]             stat_lsu_gnt_o,
    output logic [31:0]             stat_conflict_o
`endif
);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_IFU  = 2'd1,
        OWN_LSU  = 2'd2
    } owner_e;

    owner_e     owner_r;
    owner_e     owner_next_s;
    logic [3:0] stall_cnt_r;
    logic       stall_hit_s;
    logic       ifu_win_s;
    logic       lsu_win_s;

    assign stall_hit_s = (stall_cnt_r >= 4'(MAX_STALL));

    // Grant selection; grants are forced low while reset is asserted
    always_comb begin
        ifu_win_s = 1'b0;
        lsu_win_s = 1'b0;
        if (!rstn_i) begin
            ifu_win_s = 1'b0;
            lsu_win_s = 1'b0;
        end else if (ifu_req_i && lsu_req_i) begin
            if (stall_hit_s) begin
                ifu_win_s = 1'b1;
            end else begin
                lsu_win_s = 1'b1;
            end
        end else if (ifu_req_i) begin
            ifu_win_s = 1'b1;
        end else if (lsu_req_i) begin
            lsu_win_s = 1'b1;
        end else begin
            ifu_win_s = 1'b0;
            lsu_win_s = 1'b0;
        end
    end

    assign ifu_gnt_o = ifu_win_s;
    assign lsu_gnt_o = lsu_win_s;

    // RAM request mux from the winner; fetches are always full-word reads
    always_comb begin
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (ifu_win_s) begin
            ram_en_o   = 1'b1;
            ram_be_o   = '1;
            ram_addr_o = ifu_addr_i;
        end else if (lsu_win_s) begin
            ram_en_o    = 1'b1;
            ram_we_o    = lsu_we_i;
            ram_be_o    = lsu_be_i;
            ram_addr_o  = lsu_addr_i;
            ram_wdata_o = lsu_wdata_i;
        end else begin
            ram_en_o = 1'b0;
        end
    end

    // Response owner state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            owner_r <= OWN_IDLE;
        end else begin
            owner_r <= owner_next_s;
        end
    end

    // Owner of next cycle's RAM read data
    always_comb begin
        owner_next_s = OWN_IDLE;
        if (ifu_win_s) begin
            owner_next_s = OWN_IFU;
        end else if (lsu_win_s) begin
            owner_next_s = OWN_LSU;
        end else begin
            owner_next_s = OWN_IDLE;
        end
    end

    // Route RAM read data to the requester that owns this cycle's response
    always_comb begin
        ifu_rvalid_o = 1'b0;
        ifu_rdata_o  = '0;
        lsu_rvalid_o = 1'b0;
        lsu_rdata_o  = '0;
        case (owner_r)
            OWN_IFU: begin
                ifu_rvalid_o = 1'b1;
                ifu_rdata_o  = ram_rdata_i;
            end
            OWN_LSU: begin
                lsu_rvalid_o = 1'b1;
                lsu_rdata_o  = ram_rdata_i;
            end
            default: begin
                ifu_rvalid_o = 1'b0;
                lsu_rvalid_o = 1'b0;
            end
        endcase
    end

    // Consecutive IFU denial counter, saturating at 15
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stall_cnt_r <= 4'd0;
        end else if (ifu_req_i && !ifu_win_s) begin
            stall_cnt_r <= (stall_cnt_r == 4'd15) ? stall_cnt_r : stall_cnt_r + 4'd1;
        end else begin
            stall_cnt_r <= 4'd0;
        end
    end

`ifdef JEDRO_1_MEM_ARB_STATS_EN
    logic [31:0] stat_ifu_gnt_r;
    logic [31:0] stat_lsu_gnt_r;
    logic [31:0] stat_conflict_r;

    // Free-running wrapping grant and conflict counters
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stat_ifu_gnt_r  <= 32'd0;
            stat_lsu_gnt_r  <= 32'd0;
            stat_conflict_r <= 32'd0;
        end else begin
            stat_ifu_gnt_r  <= stat_ifu_gnt_r + 32'(ifu_win_s);
            stat_lsu_gnt_r  <= stat_lsu_gnt_r + 32'(lsu_win_s);
            stat_conflict_r <= stat_conflict_r + 32'(ifu_req_i & lsu_req_i);
        end
    end

    assign stat_ifu_gnt_o  = stat_ifu_gnt_r;
    assign stat_lsu_gnt_o  = stat_lsu_gnt_r;
    assign stat_conflict_o = stat_conflict_r;
`endif

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Directed self-checking bench for jedro_1_mem_arbiter with a behavioural
// single-port RAM (read data one cycle after enable, byte-enabled writes).
module tb_jedro_1_mem_arbiter;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        ifu_req_i;
    logic [31:0] ifu_addr_i;
    logic        ifu_gnt_o;
    logic        ifu_rvalid_o;
    logic [31:0] ifu_rdata_o;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [3:0]  lsu_be_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_gnt_o;
    logic        lsu_rvalid_o;
    logic [31:0] lsu_rdata_o;
    logic        ram_en_o;
    logic        ram_we_o;
    logic [3:0]  ram_be_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i;
`ifdef JEDRO_1_MEM_ARB_STATS_EN
    logic [31:0] stat_ifu_gnt_o;
    logic [31:0] stat_lsu_gnt_o;
    logic [31:0] stat_conflict_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    jedro_1_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_STALL(4)) dut (
        .clk_i(clk), .rstn_i(rstn_i),
        .ifu_req_i(ifu_req_i), .ifu_addr_i(ifu_addr_i), .ifu_gnt_o(ifu_gnt_o),
        .ifu_rvalid_o(ifu_rvalid_o), .ifu_rdata_o(ifu_rdata_o),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
        .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
        .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
        .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
`ifdef JEDRO_1_MEM_ARB_STATS_EN
        , .stat_ifu_gnt_o(stat_ifu_gnt_o), .stat_lsu_gnt_o(stat_lsu_gnt_o),
        .stat_conflict_o(stat_conflict_o)
`endif
    );

    // Word i initially holds 0xA0000000|i, except word 16 (addr 0x40)
    logic [31:0] mem [0:255];
    logic        ram_ready = 1'b0;
    logic [7:0]  ram_idx;
    assign ram_idx = ram_addr_o[9:2];

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
            mem[16]   <= 32'h1122_3344;
            ram_ready <= 1'b1;
        end else if (ram_en_o) begin
            ram_rdata_i <= mem[ram_idx];
            if (ram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be_o[b]) mem[ram_idx][8*b +: 8] <= ram_wdata_o[8*b +: 8];
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Apply one cycle of requests at the falling edge, settle 1 ns
    task automatic drive(input logic ir, input logic [31:0] ia, input logic lr, input logic lw,
                         input logic [3:0] lb, input logic [31:0] la, input logic [31:0] lwd);
        @(negedge clk);
        ifu_req_i = ir; ifu_addr_i = ia;
        lsu_req_i = lr; lsu_we_i = lw; lsu_be_i = lb; lsu_addr_i = la; lsu_wdata_i = lwd;
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ifu_gnt"},    32'(ifu_gnt_o),    32'd0);
        check_val({tag, "_lsu_gnt"},    32'(lsu_gnt_o),    32'd0);
        check_val({tag, "_ifu_rvalid"}, 32'(ifu_rvalid_o), 32'd0);
        check_val({tag, "_lsu_rvalid"}, 32'(lsu_rvalid_o), 32'd0);
        check_val({tag, "_ram_en"},     32'(ram_en_o),     32'd0);
        check_val({tag, "_ram_we"},     32'(ram_we_o),     32'd0);
        check_val({tag, "_ram_be"},     32'(ram_be_o),     32'd0);
        check_val({tag, "_ram_addr"},   ram_addr_o,        32'd0);
        check_val({tag, "_ram_wdata"},  ram_wdata_o,       32'd0);
    endtask

    logic [9:0] exp_ifu_win;

    initial begin
        rstn_i = 1'b0;
        ifu_req_i = 1'b1; ifu_addr_i = 32'h24;
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_be_i = 4'hF;
        lsu_addr_i = 32'h80; lsu_wdata_i = 32'h5555_AAAA;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        rstn_i = 1'b1;

        // IFU-only back-to-back reads
        drive(1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        check_val("ifu0_gnt",  32'(ifu_gnt_o), 32'd1);
        check_val("ifu0_lgnt", 32'(lsu_gnt_o), 32'd0);
        check_val("ifu0_en",   32'(ram_en_o),  32'd1);
        check_val("ifu0_we",   32'(ram_we_o),  32'd0);
        check_val("ifu0_be",   32'(ram_be_o),  32'hF);
        drive(1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        check_val("ifu1_gnt",  32'(ifu_gnt_o),    32'd1);
        check_val("ifu1_addr", ram_addr_o,        32'h4);
        check_val("ifu0_rv",   32'(ifu_rvalid_o), 32'd1);
        check_val("ifu0_data", ifu_rdata_o,       32'hA000_0000);
        check_val("ifu0_lrv",  32'(lsu_rvalid_o), 32'd0);
        drive(1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        check_val("ifu2_gnt",  32'(ifu_gnt_o),    32'd1);
        check_val("ifu1_data", ifu_rdata_o,       32'hA000_0001);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        check_val("idle_en",   32'(ram_en_o),     32'd0);
        check_val("ifu2_rv",   32'(ifu_rvalid_o), 32'd1);
        check_val("ifu2_data", ifu_rdata_o,       32'hA000_0002);
        check_val("ifu2_lrv",  32'(lsu_rvalid_o), 32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        check_val("idle_rv",   32'(ifu_rvalid_o), 32'd0);

        // Conflict: LSU write wins, IFU follows
        drive(1'b1, 32'h10, 1'b1, 1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF);
        check_val("cf_lgnt",  32'(lsu_gnt_o), 32'd1);
        check_val("cf_ignt",  32'(ifu_gnt_o), 32'd0);
        check_val("cf_we",    32'(ram_we_o),  32'd1);
        check_val("cf_wdata", ram_wdata_o,    32'hDEAD_BEEF);
        check_val("cf_addr",  ram_addr_o,     32'h100);
        drive(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        check_val("cf_ignt2", 32'(ifu_gnt_o),    32'd1);
        check_val("cf_ack",   32'(lsu_rvalid_o), 32'd1);
        check_val("cf_irv0",  32'(ifu_rvalid_o), 32'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
        check_val("cf_irv",   32'(ifu_rvalid_o), 32'd1);
        check_val("cf_idata", ifu_rdata_o,       32'hA000_0004);
        check_val("rd_lgnt",  32'(lsu_gnt_o),    32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        check_val("rd_lrv",   32'(lsu_rvalid_o), 32'd1);
        check_val("rd_ldata", lsu_rdata_o,       32'hDEAD_BEEF);
        check_val("rd_irv",   32'(ifu_rvalid_o), 32'd0);
        check_val("rd_irdata", ifu_rdata_o,      32'd0);

        // Starvation guard: IFU wins the 5th conflict cycle, then again 5 later
        exp_ifu_win = 10'b10_0001_0000;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
            check_val($sformatf("stall%0d_ignt", i), 32'(ifu_gnt_o), 32'(exp_ifu_win[i]));
            check_val($sformatf("stall%0d_lgnt", i), 32'(lsu_gnt_o), 32'(!exp_ifu_win[i]));
        end

        // Byte write into 0x11223344
        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0010, 32'h40, 32'h0000_AB00);
        check_val("bw_gnt", 32'(lsu_gnt_o), 32'd1);
        check_val("bw_be",  32'(ram_be_o),  32'h2);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
        check_val("bw_ack", 32'(lsu_rvalid_o), 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        check_val("bw_data", lsu_rdata_o, 32'h1122_AB44);

        // Asynchronous reset pulse right after an IFU grant
        drive(1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        check_val("rst_pre_gnt", 32'(ifu_gnt_o), 32'd1);
        #2 rstn_i = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        rstn_i = 1'b1;
        ifu_req_i = 1'b0;
        #1;
        check_val("rst_no_rv", 32'(ifu_rvalid_o), 32'd0);

`ifdef JEDRO_1_MEM_ARB_STATS_EN
        check_val("stat_clr", stat_ifu_gnt_o, 32'd0);
        drive(1'b1, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        drive(1'b1, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        drive(1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        check_val("stat_ifu",  stat_ifu_gnt_o,  32'd3);
        check_val("stat_lsu",  stat_lsu_gnt_o,  32'd2);
        check_val("stat_conf", stat_conflict_o, 32'd2);
`endif

        // Normal operation after reset
        drive(1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        check_val("post_gnt", 32'(ifu_gnt_o), 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        check_val("post_rv",   32'(ifu_rvalid_o), 32'd1);
        check_val("post_data", ifu_rdata_o,       32'hA000_0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
